// File: rtl/neighbor_window.sv
// Streaming 3x3 neighbourhood extractor for a raster-scanned binary grid.
// Emits each cell with its eight neighbours; cells off the grid read as 0.
module neighbor_window #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_cell,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      n,
    output logic                      ne,
    output logic                      e,
    output logic                      se,
    output logic                      s,
    output logic                      sw,
    output logic                      w,
    output logic                      nw,
    output logic                      center,
    output logic [$clog2(WIDTH)-1:0]  out_x,
    output logic [$clog2(HEIGHT)-1:0] out_y,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int LAG_I = WIDTH + 2;
    localparam int PW    = $clog2(LAG_I + 1);
    localparam int SL    = 2 * WIDTH + 3;

    localparam logic [PW-1:0] LAG  = PW'(LAG_I);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    // Window taps: bit 0 is the newest cell, i.e. the SE neighbour.
    localparam int T_SE = 0;
    localparam int T_S  = 1;
    localparam int T_SW = 2;
    localparam int T_E  = WIDTH;
    localparam int T_C  = WIDTH + 1;
    localparam int T_W  = WIDTH + 2;
    localparam int T_NE = 2 * WIDTH;
    localparam int T_N  = 2 * WIDTH + 1;
    localparam int T_NW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        FLUSH
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            run_q;
    logic [PW-1:0]   pend_q;
    logic [PW-1:0]   pend_d;
    logic [SL-1:0]   win_q;
    logic [SL-1:0]   win_d;
    logic [XW-1:0]   ix_q;
    logic [YW-1:0]   iy_q;
    logic [XW-1:0]   ex_q;
    logic [YW-1:0]   ey_q;

    logic            acc;
    logic            xfer;
    logic            last_in;
    logic            load;
    logic            shift;
    logic            shift_bit;
    logic            frame_done;
    logic            top;
    logic            bot;
    logic            lft;
    logic            rgt;

    assign in_ready = run_q && (state_q != FLUSH) &&
                      ((pend_q < LAG) ||
                       ((pend_q == LAG) && out_valid && out_ready));

    assign acc       = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign last_in   = (ix_q == XMAX) && (iy_q == YMAX);
    assign shift_bit = acc & in_cell;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q + PW'(acc) - PW'(xfer);
        load       = 1'b0;
        shift      = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            FILL: begin
                shift = acc;
                if (acc && pend_d == LAG) begin
                    load    = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                shift = acc;
                if (acc && pend_d == LAG)
                    load = 1'b1;
                if (acc && last_in)
                    state_d = FLUSH;
            end
            FLUSH: begin
                // Past the last input, zeros stand in for the missing cells.
                if (xfer && pend_q > ONE) begin
                    shift = 1'b1;
                    load  = 1'b1;
                end
                if (xfer && out_last) begin
                    state_d    = FILL;
                    pend_d     = '0;
                    frame_done = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign win_d = shift ? {win_q[SL-2:0], shift_bit} : win_q;

    assign top = (ey_q == '0);
    assign bot = (ey_q == YMAX);
    assign lft = (ex_q == '0);
    assign rgt = (ex_q == XMAX);

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            run_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ix_q <= '0;
            iy_q <= '0;
        end else if (frame_done) begin
            ix_q <= '0;
            iy_q <= '0;
        end else if (acc) begin
            if (ix_q == XMAX) begin
                ix_q <= '0;
                iy_q <= (iy_q == YMAX) ? '0 : iy_q + 1'b1;
            end else begin
                ix_q <= ix_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
            ey_q <= '0;
        end else if (frame_done) begin
            ex_q <= '0;
            ey_q <= '0;
        end else if (load) begin
            if (ex_q == XMAX) begin
                ex_q <= '0;
                ey_q <= (ey_q == YMAX) ? '0 : ey_q + 1'b1;
            end else begin
                ex_q <= ex_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            n         <= 1'b0;
            ne        <= 1'b0;
            e         <= 1'b0;
            se        <= 1'b0;
            s         <= 1'b0;
            sw        <= 1'b0;
            w         <= 1'b0;
            nw        <= 1'b0;
            center    <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            // Off-grid neighbours are masked by position, not by buffer data.
            out_valid <= 1'b1;
            n         <= win_d[T_N]  & ~top;
            ne        <= win_d[T_NE] & ~top & ~rgt;
            e         <= win_d[T_E]  & ~rgt;
            se        <= win_d[T_SE] & ~bot & ~rgt;
            s         <= win_d[T_S]  & ~bot;
            sw        <= win_d[T_SW] & ~bot & ~lft;
            w         <= win_d[T_W]  & ~lft;
            nw        <= win_d[T_NW] & ~top & ~lft;
            center    <= win_d[T_C];
            out_x     <= ex_q;
            out_y     <= ey_q;
            out_last  <= rgt && bot;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_neighbor_window.sv
// Randomized bench for neighbor_window on a 4x4 grid.
// Outputs are checked against a bounds-checked neighbour lookup model.
module tb_neighbor_window;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_cell = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       n, ne, e, se, s, sw, w, nw, center;
    logic [1:0] out_x;
    logic [1:0] out_y;
    logic       out_last;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [8:0] nb;
        int         x;
        int         y;
        logic       last;
    } obs_t;

    obs_t out_q[$];
    bit   in_q[$];
    bit   fr[2][N];

    neighbor_window #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_cell(in_cell), .in_valid(in_valid), .in_ready(in_ready),
        .n(n), .ne(ne), .e(e), .se(se), .s(s), .sw(sw), .w(w), .nw(nw),
        .center(center), .out_x(out_x), .out_y(out_y),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [8:0] bundle();
        return {n, ne, e, se, s, sw, w, nw, center};
    endfunction

    function automatic bit cell_at(int k, int x, int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 1'b0;
        return fr[k][y * W + x];
    endfunction

    // Bit order: {N, NE, E, SE, S, SW, W, NW, CENTER}
    function automatic logic [8:0] model(int k, int x, int y);
        return {cell_at(k, x, y - 1), cell_at(k, x + 1, y - 1),
                cell_at(k, x + 1, y), cell_at(k, x + 1, y + 1),
                cell_at(k, x, y + 1), cell_at(k, x - 1, y + 1),
                cell_at(k, x - 1, y), cell_at(k, x - 1, y - 1),
                cell_at(k, x, y)};
    endfunction

    task automatic load_frame(int k);
        for (int i = 0; i < N; i++) in_q.push_back(fr[k][i]);
    endtask

    task automatic rand_frame(int k, int density);
        for (int i = 0; i < N; i++)
            fr[k][i] = ($urandom_range(99) < density);
    endtask

    // Drives queued cells and records transferred bundles; starts at a negedge.
    task automatic run(int n_out, int p_in, int p_out);
        int   cyc = 0;
        obs_t o;
        while (out_q.size() < n_out && cyc < 3000) begin
            in_valid  = (in_q.size() > 0) && ($urandom_range(99) < p_in);
            in_cell   = (in_q.size() > 0) ? in_q[0] : 1'b0;
            out_ready = ($urandom_range(99) < p_out);
            #1;
            if (out_valid && out_ready) begin
                o.nb   = bundle();
                o.x    = int'(out_x);
                o.y    = int'(out_y);
                o.last = out_last;
                out_q.push_back(o);
            end
            if (in_valid && in_ready) void'(in_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (out_q.size() < n_out) begin
            fails++;
            $display("FAIL run_budget: got %0d outputs, need %0d",
                     out_q.size(), n_out);
        end
    endtask

    task automatic test_reset();
        int cyc = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({in_ready, out_valid, bundle(), out_x, out_y, out_last} !== '0) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b nb=%b x=%0d y=%0d last=%b, need all 0",
                     in_ready, out_valid, bundle(), out_x, out_y, out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: got %b, need 0", in_ready);
        end
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_edge: got %b, need 1", in_ready);
        end
        @(negedge clk);
        while (cyc < 20) begin
            in_valid = 1'b1;
            in_cell  = $urandom_range(1);
            #1;
            if (out_valid) break;
            @(negedge clk);
            cyc++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got vld=%b rdy=%b, need 0 0",
                     out_valid, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_cell();
        for (int i = 0; i < N; i++) fr[0][i] = (i == 5);
        out_q.delete();
        load_frame(0);
        run(N, 100, 100);
        for (int i = 0; i < N; i++) begin
            tests++;
            if (out_q.size() <= i) begin
                fails++;
                $display("FAIL single_cell%0d: missing output", i);
            end else if (out_q[i].nb !== model(0, i % W, i / W) ||
                         out_q[i].x != i % W || out_q[i].y != i / W ||
                         out_q[i].last !== (i == N - 1)) begin
                fails++;
                $display("FAIL single_cell%0d: got nb=%b x=%0d y=%0d last=%b, need nb=%b x=%0d y=%0d last=%b",
                         i, out_q[i].nb, out_q[i].x, out_q[i].y, out_q[i].last,
                         model(0, i % W, i / W), i % W, i / W, i == N - 1);
            end
        end
        if (out_q.size() >= N) begin
            tests++;
            if (out_q[0].nb !== 9'h020 || out_q[5].nb !== 9'h001 ||
                out_q[10].nb !== 9'h002) begin
                fails++;
                $display("FAIL single_fixed: got %h %h %h, need 020 001 002",
                         out_q[0].nb, out_q[5].nb, out_q[10].nb);
            end
        end
    endtask

    task automatic test_all_live();
        for (int i = 0; i < N; i++) fr[0][i] = 1'b1;
        out_q.delete();
        load_frame(0);
        run(N, 70, 60);
        if (out_q.size() >= N) begin
            tests++;
            if (out_q[0].nb !== 9'h071 || out_q[1].nb !== 9'h07D ||
                out_q[5].nb !== 9'h1FF || out_q[15].nb !== 9'h107) begin
                fails++;
                $display("FAIL all_live: got %h %h %h %h, need 071 07d 1ff 107",
                         out_q[0].nb, out_q[1].nb, out_q[5].nb, out_q[15].nb);
            end
            tests++;
            if ($countones(out_q[1].nb[8:1]) != 5) begin
                fails++;
                $display("FAIL all_live_count: got %0d neighbours at (1,0), need 5",
                         $countones(out_q[1].nb[8:1]));
            end
        end
        for (int i = 0; i < N; i++) begin
            tests++;
            if (out_q.size() <= i || out_q[i].nb !== model(0, i % W, i / W)) begin
                fails++;
                $display("FAIL all_live_cell%0d: output wrong or missing", i);
            end
        end
    endtask

    task automatic test_stall();
        int         cyc = 0;
        logic [8:0] held;
        logic [1:0] hx, hy;
        bit         stable = 1'b1;
        bit         blocked = 1'b1;
        rand_frame(0, 40);
        out_q.delete();
        load_frame(0);
        while (cyc < 40) begin
            in_valid  = 1'b1;
            in_cell   = in_q[0];
            out_ready = 1'b0;
            #1;
            if (out_valid) break;
            if (in_ready) void'(in_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (N - in_q.size() != W + 2 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_pending: got %0d accepted rdy=%b, need 6 rdy=0",
                     N - in_q.size(), in_ready);
        end
        held = bundle();
        hx   = out_x;
        hy   = out_y;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (bundle() !== held || out_x !== hx || out_y !== hy || !out_valid)
                stable = 1'b0;
            if (in_ready) blocked = 1'b0;
        end
        tests++;
        if (!stable || held !== model(0, 0, 0)) begin
            fails++;
            $display("FAIL stall_hold: got nb=%b stable=%0d, need nb=%b stable=1",
                     held, stable, model(0, 0, 0));
        end
        tests++;
        if (!blocked) begin
            fails++;
            $display("FAIL stall_ready: got ready high during stall, need 0");
        end
        in_valid = 1'b0;
        @(negedge clk);
        run(N, 80, 100);
        for (int i = 0; i < N; i++) begin
            tests++;
            if (out_q.size() <= i || out_q[i].nb !== model(0, i % W, i / W) ||
                out_q[i].x != i % W || out_q[i].y != i / W) begin
                fails++;
                $display("FAIL stall_cell%0d: output wrong or missing", i);
            end
        end
    endtask

    task automatic test_back_to_back();
        rand_frame(0, 50);
        rand_frame(1, 50);
        out_q.delete();
        load_frame(0);
        load_frame(1);
        run(2 * N, 60, 60);
        for (int i = 0; i < 2 * N; i++) begin
            int k = i / N;
            int j = i % N;
            tests++;
            if (out_q.size() <= i) begin
                fails++;
                $display("FAIL b2b_cell%0d: missing output", i);
            end else if (out_q[i].nb !== model(k, j % W, j / W) ||
                         out_q[i].x != j % W || out_q[i].y != j / W ||
                         out_q[i].last !== (j == N - 1)) begin
                fails++;
                $display("FAIL b2b_cell%0d: got nb=%b x=%0d y=%0d last=%b, need nb=%b x=%0d y=%0d last=%b",
                         i, out_q[i].nb, out_q[i].x, out_q[i].y, out_q[i].last,
                         model(k, j % W, j / W), j % W, j / W, j == N - 1);
            end
        end
        if (out_q.size() >= N + 1) begin
            tests++;
            if (out_q[N - 1].last !== 1'b1 || out_q[N].x != 0 || out_q[N].y != 0) begin
                fails++;
                $display("FAIL b2b_boundary: got last=%b next=(%0d,%0d), need 1 (0,0)",
                         out_q[N - 1].last, out_q[N].x, out_q[N].y);
            end
        end
    endtask

    task automatic test_midframe_reset();
        int cnt = 0;
        int cyc = 0;
        while (cnt < 7 && cyc < 40) begin
            in_valid  = 1'b1;
            in_cell   = 1'b1;
            out_ready = 1'b1;
            #1;
            if (in_ready) cnt++;
            @(negedge clk);
            cyc++;
        end
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_q.delete();
        out_q.delete();
        rand_frame(0, 25);
        load_frame(0);
        run(N, 75, 75);
        for (int i = 0; i < N; i++) begin
            tests++;
            if (out_q.size() <= i || out_q[i].nb !== model(0, i % W, i / W) ||
                out_q[i].x != i % W || out_q[i].y != i / W) begin
                fails++;
                $display("FAIL abort_cell%0d: output wrong or missing", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_all_live();
        test_stall();
        test_back_to_back();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
